// File: rtl/pour_timer.sv
// Timed pump-enable generator: serves one pour request at a time and holds the
// selected channel's toggle high for a whole number of prescaled seconds.
module pour_timer #(
  parameter int CLK_HZ = 50000000,
  parameter int SEC_W  = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             out_ctrl0,
  input  logic             out_ctrl1,
  input  logic             out_ctrl2,
  input  logic             out_ctrl3,
  input  logic [SEC_W-1:0] pour_sec,
  output logic             out0,
  output logic             out1,
  output logic             out2,
  output logic             out3,
  output logic             busy,
  output logic [SEC_W-1:0] sec_left,
  output logic             done
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    POUR,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [3:0]       out_q, out_d;
  logic             done_q, done_d;

  logic [3:0]       ctrl;
  logic [1:0]       pick;
  logic             wrap;

  assign ctrl = {out_ctrl3, out_ctrl2, out_ctrl1, out_ctrl0};
  assign wrap = (presc_q == PW'(CLK_HZ - 1));

  // Fixed priority: lowest channel index wins.
  always_comb begin
    pick = 2'd3;
    if (ctrl[0])      pick = 2'd0;
    else if (ctrl[1]) pick = 2'd1;
    else if (ctrl[2]) pick = 2'd2;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      chan_q  <= '0;
      presc_q <= '0;
      sec_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|ctrl) begin
          chan_d  = pick;
          sec_d   = (pour_sec == '0) ? SEC_W'(1) : pour_sec;
          presc_d = '0;
          out_d   = 4'b0001 << pick;
          state_d = POUR;
        end
      end
      POUR: begin
        // A dropped request aborts before any pending second tick is honoured.
        if (!ctrl[chan_q]) begin
          out_d   = '0;
          sec_d   = '0;
          presc_d = '0;
          state_d = IDLE;
        end else if (wrap) begin
          presc_d = '0;
          if (sec_q == SEC_W'(1)) begin
            sec_d   = '0;
            out_d   = '0;
            done_d  = 1'b1;
            state_d = RELEASE;
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      RELEASE: begin
        if (ctrl == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out0     = out_q[0];
  assign out1     = out_q[1];
  assign out2     = out_q[2];
  assign out3     = out_q[3];
  assign busy     = (state_q != IDLE);
  assign sec_left = sec_q;
  assign done     = done_q;

endmodule
